imm_instr_encoder: RTL and testbench

IMM_INSTR_ENCODER -- requirements
Module: imm_instr_encoder

---
 rtl/imm_instr_encoder.sv | 125 ++++++++++++
 tb/tb_imm_instr_encoder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/imm_instr_encoder.sv
// Immediate-format instruction encoder (I/S/B/J) with range/alignment checking,
// feeding a DEPTH-entry in-order output FIFO and a saturating error counter.
module imm_instr_encoder #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               imm_type,
  input  logic [31:0]              imm,
  input  logic [6:0]               opcode,
  input  logic [2:0]               funct3,
  input  logic [4:0]               rs1,
  input  logic [4:0]               rs2,
  input  logic [4:0]               rd,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic                     out_err,
  output logic [$clog2(DEPTH):0]   level,
  output logic [7:0]               err_cnt,
  input  logic                     err_clr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FMT_I = 2'b00,
    FMT_S = 2'b01,
    FMT_B = 2'b10,
    FMT_J = 2'b11
  } fmt_e;

  fmt_e        fmt;
  logic [31:0] raw_instr;
  logic        range_ok;
  logic [31:0] enc_instr;
  logic        enc_err;

  logic [32:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic [32:0]   head;
  logic          push, pop;

  assign fmt = fmt_e'(imm_type);

  always_comb begin
    raw_instr = '0;
    range_ok  = 1'b0;
    unique case (fmt)
      FMT_I: begin
        raw_instr = {imm[11:0], rs1, funct3, rd, opcode};
        range_ok  = (&imm[31:11]) | ~(|imm[31:11]);
      end
      FMT_S: begin
        raw_instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        range_ok  = (&imm[31:11]) | ~(|imm[31:11]);
      end
      FMT_B: begin
        raw_instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        range_ok  = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
      end
      FMT_J: begin
        raw_instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        range_ok  = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
      end
      default: begin
        raw_instr = '0;
        range_ok  = 1'b0;
      end
    endcase
    enc_err   = ~range_ok;
    enc_instr = range_ok ? raw_instr : NOP_INSTR;
  end

  // Handshake flags come only from registered occupancy, so in_ready never
  // combinationally depends on out_ready.
  assign in_ready  = (level_q != (AW+1)'(DEPTH));
  assign out_valid = (level_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    err_cnt_d = err_cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (!push && pop) level_d = level_q - 1'b1;
    if (err_clr)                                    err_cnt_d = '0;
    else if (push && enc_err && err_cnt_q != '1)    err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {enc_err, enc_instr};
  end

  assign head      = mem_q[rd_ptr_q];
  assign out_instr = out_valid ? head[31:0] : '0;
  assign out_err   = out_valid & head[32];
  assign level     = level_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_imm_instr_encoder.sv
// Directed self-checking bench for imm_instr_encoder: encodings, range errors,
// counter saturation/clear, FIFO backpressure, push+pop, and async reset.
module tb_imm_instr_encoder;

  logic        clk, rst_n;
  logic        in_valid, in_ready;
  logic [1:0]  imm_type;
  logic [31:0] imm;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic        out_valid, out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [2:0]  level;
  logic [7:0]  err_cnt;
  logic        err_clr;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  imm_instr_encoder #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .imm_type(imm_type), .imm(imm), .opcode(opcode), .funct3(funct3),
    .rs1(rs1), .rs2(rs2), .rd(rd), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err), .level(level), .err_cnt(err_cnt),
    .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  t;
    logic [31:0] imm;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  r1, r2, rd;
    logic [31:0] exp;
    logic        err;
  } vec_t;

  vec_t        vt [14];
  logic [31:0] bp_exp [4];
  int unsigned exp_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] t, input logic [31:0] im, input logic [6:0] op,
                       input logic [2:0] f3, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] d);
    imm_type = t; imm = im; opcode = op; funct3 = f3; rs1 = r1; rs2 = r2; rd = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    vt[0]  = '{2'b00, 32'hFFFF_FFFF, 7'h13, 3'd0, 5'd6, 5'd0, 5'd5, 32'hFFF3_0293, 1'b0};
    vt[1]  = '{2'b01, 32'h0000_0008, 7'h23, 3'd2, 5'd1, 5'd2, 5'd0, 32'h0020_A423, 1'b0};
    vt[2]  = '{2'b11, 32'h0000_0010, 7'h6F, 3'd0, 5'd0, 5'd0, 5'd1, 32'h0100_00EF, 1'b0};
    vt[3]  = '{2'b10, 32'h0000_0008, 7'h63, 3'd0, 5'd1, 5'd2, 5'd0, 32'h0020_8463, 1'b0};
    vt[4]  = '{2'b10, 32'hFFFF_FFFE, 7'h63, 3'd0, 5'd0, 5'd0, 5'd0, 32'hFE00_0FE3, 1'b0};
    vt[5]  = '{2'b00, 32'h0000_07FF, 7'h13, 3'd0, 5'd0, 5'd0, 5'd0, 32'h7FF0_0013, 1'b0};
    vt[6]  = '{2'b00, 32'h0000_0800, 7'h13, 3'd0, 5'd0, 5'd0, 5'd0, 32'h0000_0013, 1'b1};
    vt[7]  = '{2'b00, 32'hFFFF_F800, 7'h13, 3'd0, 5'd0, 5'd0, 5'd0, 32'h8000_0013, 1'b0};
    vt[8]  = '{2'b01, 32'hFFFF_F7FF, 7'h23, 3'd2, 5'd1, 5'd2, 5'd0, 32'h0000_0013, 1'b1};
    vt[9]  = '{2'b11, 32'h0000_0001, 7'h6F, 3'd0, 5'd0, 5'd0, 5'd1, 32'h0000_0013, 1'b1};
    vt[10] = '{2'b11, 32'h0010_0000, 7'h6F, 3'd0, 5'd0, 5'd0, 5'd1, 32'h0000_0013, 1'b1};
    vt[11] = '{2'b11, 32'hFFF0_0000, 7'h6F, 3'd0, 5'd0, 5'd0, 5'd0, 32'h8000_006F, 1'b0};
    vt[12] = '{2'b10, 32'h0000_0003, 7'h63, 3'd0, 5'd1, 5'd2, 5'd0, 32'h0000_0013, 1'b1};
    vt[13] = '{2'b10, 32'h0000_1000, 7'h63, 3'd0, 5'd1, 5'd2, 5'd0, 32'h0000_0013, 1'b1};
    bp_exp[0] = 32'h0010_0013; bp_exp[1] = 32'h0020_0013;
    bp_exp[2] = 32'h0030_0013; bp_exp[3] = 32'h0040_0013;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
    drive(2'b00, '0, '0, '0, '0, '0, '0);
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_level",     32'(level),     32'd0);
    check("rst_err_cnt",   32'(err_cnt),   32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_instr", out_instr,      32'd0);
    check("rst_out_err",   32'(out_err),   32'd0);
    #10 rst_n = 1'b1;
    tick();

    // Encoding vectors: one push, inspect head, one pop.
    exp_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      drive(vt[i].t, vt[i].imm, vt[i].op, vt[i].f3, vt[i].r1, vt[i].r2, vt[i].rd);
      send();
      if (vt[i].err) exp_cnt++;
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d_instr", i), out_instr, vt[i].exp);
      check($sformatf("vec%0d_err", i),   32'(out_err), 32'(vt[i].err));
      check($sformatf("vec%0d_level", i), 32'(level), 32'd1);
      check($sformatf("vec%0d_errcnt", i), 32'(err_cnt), 32'(exp_cnt));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check($sformatf("vec%0d_drained", i), 32'(level), 32'd0);
      check($sformatf("vec%0d_idle_instr", i), out_instr, 32'd0);
    end

    // Saturation: 300 misaligned B requests streamed through.
    drive(2'b10, 32'h0000_0003, 7'h63, 3'd0, 5'd1, 5'd2, 5'd0);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    repeat (300) tick();
    in_valid = 1'b0;
    tick();
    check("sat_err_cnt", 32'(err_cnt), 32'd255);
    check("sat_level",   32'(level),   32'd0);

    in_valid = 1'b1; err_clr = 1'b1;
    tick();
    in_valid = 1'b0; err_clr = 1'b0;
    check("clr_override", 32'(err_cnt), 32'd0);
    tick();
    send();
    check("post_clr_cnt",   32'(err_cnt), 32'd1);
    check("post_clr_err",   32'(out_err), 32'd1);
    check("post_clr_instr", out_instr,    32'h0000_0013);
    tick();
    out_ready = 1'b0;
    check("post_clr_drain", 32'(level), 32'd0);

    // Backpressure: five back-to-back pushes into a stalled 4-deep FIFO.
    in_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      drive(2'b00, 32'(k), 7'h13, 3'd0, 5'd0, 5'd0, 5'd0);
      tick();
    end
    in_valid = 1'b0;
    check("bp_level",    32'(level),    32'd4);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("bp_head%0d", k), out_instr, bp_exp[k]);
      tick();
      if (k == 0) check("bp_ready_after_pop", 32'(in_ready), 32'd1);
    end
    out_ready = 1'b0;
    check("bp_empty", 32'(out_valid), 32'd0);

    // Simultaneous push and pop at level 2.
    drive(2'b00, 32'h0000_000A, 7'h13, 3'd0, 5'd0, 5'd0, 5'd0); send();
    drive(2'b00, 32'h0000_000B, 7'h13, 3'd0, 5'd0, 5'd0, 5'd0); send();
    check("sim_level_pre", 32'(level), 32'd2);
    drive(2'b00, 32'h0000_000C, 7'h13, 3'd0, 5'd0, 5'd0, 5'd0);
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("sim_level", 32'(level), 32'd2);
    check("sim_head",  out_instr,  32'h00B0_0013);
    tick();
    check("sim_tail",  out_instr,  32'h00C0_0013);
    tick();
    tick();
    check("empty_pop_level", 32'(level),     32'd0);
    check("empty_pop_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Asynchronous reset with three entries queued.
    drive(2'b00, 32'h0000_0001, 7'h13, 3'd0, 5'd0, 5'd0, 5'd0); send();
    drive(2'b10, 32'h0000_0003, 7'h63, 3'd0, 5'd0, 5'd0, 5'd0); send();
    drive(2'b00, 32'h0000_0002, 7'h13, 3'd0, 5'd0, 5'd0, 5'd0); send();
    check("mid_level",   32'(level),   32'd3);
    check("mid_err_cnt", 32'(err_cnt), 32'd2);
    #3 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_level",     32'(level),     32'd0);
    check("arst_err_cnt",   32'(err_cnt),   32'd0);
    check("arst_in_ready",  32'(in_ready),  32'd1);
    tick();
    #3 rst_n = 1'b1;
    #1;
    drive(2'b00, 32'h0000_0005, 7'h13, 3'd0, 5'd0, 5'd0, 5'd0);
    send();
    check("rel_out_valid", 32'(out_valid), 32'd1);
    check("rel_level",     32'(level),     32'd1);
    check("rel_instr",     out_instr,      32'h0050_0013);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
